// File: rtl/snk68_snd_pkg.sv
// rtl/snk68_snd_pkg.sv - shared types and constants for the SNK68 sound-command bridge
//
// Purpose: default NMI pulse length, NMI FSM state encoding and the packed
//          layout of the status nibble reported by snd_latch_bridge.
// Ports:   none (package)
package snk68_snd_pkg;

  localparam int NMI_PULSE_DEFAULT = 16;

  typedef enum logic {
    NMI_IDLE,
    NMI_PULSE
  } nmi_state_t;

  typedef struct packed {
    logic ovr2;
    logic ovr1;
    logic pend2;
    logic pend1;
  } snd_status_t;

endpackage

// File: rtl/snd_nmi_pulse.sv
// rtl/snd_nmi_pulse.sv - Z80 NMI pulse generator (counter + IDLE/PULSE FSM)
//
// Purpose: drives nmi_n low for exactly PULSE_LEN clk cycles after a trigger.
//          A trigger while already pulsing reloads the counter, stretching the
//          pulse without creating a second falling edge.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous reset, active low (forces nmi_n high, FSM idle)
//   trigger  in   one-cycle command-write strobe
//   nmi_n    out  registered NMI, active low
module snd_nmi_pulse #(
  parameter int PULSE_LEN = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trigger,
  output logic nmi_n
);
  import snk68_snd_pkg::*;

  // Counter holds the number of low cycles still owed after the current one.
  localparam logic [7:0] LOAD = 8'(PULSE_LEN - 1);

  nmi_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       nmi_n_q, nmi_n_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nmi_n_d = nmi_n_q;
    if (trigger) begin
      state_d = NMI_PULSE;
      cnt_d   = LOAD;
      nmi_n_d = 1'b0;
    end else begin
      case (state_q)
        NMI_PULSE: begin
          if (cnt_q == 8'd0) begin
            state_d = NMI_IDLE;
            nmi_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= NMI_IDLE;
      cnt_q   <= 8'd0;
      nmi_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nmi_n_q <= nmi_n_d;
    end
  end

  assign nmi_n = nmi_n_q;

endmodule

// File: rtl/snd_latch_bridge.sv
// rtl/snd_latch_bridge.sv - SNK68 68K<->Z80 sound latch bridge with NMI generation
//
// Purpose: holds soundlatch (68K->Z80) and soundlatch2 (Z80->68K), fires a Z80
//          NMI on every 68K command write and, when SND_LATCH_STATUS_EN is
//          defined, tracks pending/overrun flags for both directions.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   m68k_latch_cs        68K write cycle to the command latch (level)
//   m68k_uds_n           68K upper data strobe; command byte needs uds_n=0
//   m68k_dout[15:0]      68K write data, command byte in [15:8]
//   z80_latch_read_cs    68K read of soundlatch2 (level, consume event)
//   z80_latch_cs         Z80 access to the latch address (level)
//   z80_rd_n, z80_wr_n   Z80 strobes qualifying z80_latch_cs
//   z80_dout[7:0]        Z80 write data
//   z80_latch_dout[7:0]  soundlatch to Z80 read mux
//   m68k_latch2_dout     {soundlatch2, soundlatch2} to 68K read mux
//   z80_nmi_n            Z80 NMI, active low
//   snd_status[3:0]      {ovr2, ovr1, pend2, pend1}; 0 without SND_LATCH_STATUS_EN
module snd_latch_bridge #(
  parameter int NMI_PULSE = snk68_snd_pkg::NMI_PULSE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m68k_latch_cs,
  input  logic        m68k_uds_n,
  input  logic [15:0] m68k_dout,
  input  logic        z80_latch_read_cs,
  input  logic        z80_latch_cs,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic [7:0]  z80_dout,
  output logic [7:0]  z80_latch_dout,
  output logic [15:0] m68k_latch2_dout,
  output logic        z80_nmi_n,
  output logic [3:0]  snd_status
);
  import snk68_snd_pkg::*;

  // Delayed copies of each select; a rise fires once per bus cycle however long.
  logic m68k_cs_q, m68k_cs_d;
  logic z80_wr_q, z80_wr_d;
  logic z80_rd_q, z80_rd_d;
  logic rd2_cs_q, rd2_cs_d;
  logic [7:0] latch1_q, latch1_d;
  logic [7:0] latch2_q, latch2_d;

  logic cmd_write, z80_wr_rise, z80_rd_rise, rd2_rise;

  assign m68k_cs_d = m68k_latch_cs;
  assign z80_wr_d  = z80_latch_cs & ~z80_wr_n;
  assign z80_rd_d  = z80_latch_cs & ~z80_rd_n;
  assign rd2_cs_d  = z80_latch_read_cs;

  // Lower-byte-only 68K writes carry no command and are ignored entirely.
  assign cmd_write   = m68k_cs_d & ~m68k_cs_q & ~m68k_uds_n;
  assign z80_wr_rise = z80_wr_d & ~z80_wr_q;
  assign z80_rd_rise = z80_rd_d & ~z80_rd_q;
  assign rd2_rise    = rd2_cs_d & ~rd2_cs_q;

  always_comb begin
    latch1_d = latch1_q;
    latch2_d = latch2_q;
    if (cmd_write)   latch1_d = m68k_dout[15:8];
    if (z80_wr_rise) latch2_d = z80_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m68k_cs_q <= 1'b0;
      z80_wr_q  <= 1'b0;
      z80_rd_q  <= 1'b0;
      rd2_cs_q  <= 1'b0;
      latch1_q  <= 8'h00;
      latch2_q  <= 8'h00;
    end else begin
      m68k_cs_q <= m68k_cs_d;
      z80_wr_q  <= z80_wr_d;
      z80_rd_q  <= z80_rd_d;
      rd2_cs_q  <= rd2_cs_d;
      latch1_q  <= latch1_d;
      latch2_q  <= latch2_d;
    end
  end

  assign z80_latch_dout   = latch1_q;
  assign m68k_latch2_dout = {latch2_q, latch2_q};

  snd_nmi_pulse #(
    .PULSE_LEN (NMI_PULSE)
  ) u_nmi (
    .clk     (clk),
    .reset_n (reset_n),
    .trigger (cmd_write),
    .nmi_n   (z80_nmi_n)
  );

`ifdef SND_LATCH_STATUS_EN
  snd_status_t status_q, status_d;

  // Set has priority over a same-cycle consume, so a write racing a read
  // leaves the new value flagged as pending.
  always_comb begin
    status_d = status_q;
    if (cmd_write)        status_d.pend1 = 1'b1;
    else if (z80_rd_rise) status_d.pend1 = 1'b0;
    if (z80_wr_rise)      status_d.pend2 = 1'b1;
    else if (rd2_rise)    status_d.pend2 = 1'b0;
    if (cmd_write && status_q.pend1)   status_d.ovr1 = 1'b1;
    if (z80_wr_rise && status_q.pend2) status_d.ovr2 = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) status_q <= '0;
    else          status_q <= status_d;
  end

  assign snd_status = status_q;

  logic unused_bits;
  assign unused_bits = ^m68k_dout[7:0];
`else
  assign snd_status = 4'h0;

  logic unused_bits;
  assign unused_bits = ^{m68k_dout[7:0], z80_rd_rise, rd2_rise};
`endif

endmodule

// File: tb/tb_snd_latch_bridge.sv
// tb/tb_snd_latch_bridge.sv - self-checking bench for snd_latch_bridge
module tb_snd_latch_bridge;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m68k_latch_cs;
  logic        m68k_uds_n;
  logic [15:0] m68k_dout;
  logic        z80_latch_read_cs;
  logic        z80_latch_cs;
  logic        z80_rd_n;
  logic        z80_wr_n;
  logic [7:0]  z80_dout;
  logic [7:0]  z80_latch_dout;
  logic [15:0] m68k_latch2_dout;
  logic        z80_nmi_n;
  logic [3:0]  snd_status;

  snd_latch_bridge #(.NMI_PULSE(N)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .m68k_latch_cs     (m68k_latch_cs),
    .m68k_uds_n        (m68k_uds_n),
    .m68k_dout         (m68k_dout),
    .z80_latch_read_cs (z80_latch_read_cs),
    .z80_latch_cs      (z80_latch_cs),
    .z80_rd_n          (z80_rd_n),
    .z80_wr_n          (z80_wr_n),
    .z80_dout          (z80_dout),
    .z80_latch_dout    (z80_latch_dout),
    .m68k_latch2_dout  (m68k_latch2_dout),
    .z80_nmi_n         (z80_nmi_n),
    .snd_status        (snd_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int falls = 0;
  always @(negedge z80_nmi_n) falls = falls + 1;

  int total = 0;
  int bad = 0;

  // Reference model: latch contents, flags and the clk-edge count at which
  // the NMI line is due to return high.
  logic [7:0] m_l1, m_l2;
  bit m_p1, m_o1, m_p2, m_o2;
  int m_rel;

  function automatic logic [3:0] m_status();
`ifdef SND_LATCH_STATUS_EN
    return {m_o2, m_o1, m_p2, m_p1};
`else
    return 4'h0;
`endif
  endfunction

  function automatic logic m_nmi();
    return (cyc >= m_rel) ? 1'b1 : 1'b0;
  endfunction

  // Model actions take effect at the clk edge after the negedge that drives them.
  task automatic model_reset();
    m_l1 = 8'h00; m_l2 = 8'h00;
    m_p1 = 0; m_o1 = 0; m_p2 = 0; m_o2 = 0;
    m_rel = 0;
  endtask

  task automatic model_cmd(input logic [7:0] b);
    if (m_p1) m_o1 = 1;
    m_p1 = 1;
    m_l1 = b;
    m_rel = cyc + 1 + N;
  endtask

  task automatic model_z80_wr(input logic [7:0] b);
    if (m_p2) m_o2 = 1;
    m_p2 = 1;
    m_l2 = b;
  endtask

  task automatic bus_idle();
    m68k_latch_cs = 0; m68k_uds_n = 1;
    z80_latch_read_cs = 0;
    z80_latch_cs = 0; z80_rd_n = 1; z80_wr_n = 1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    bus_idle();
    repeat (2) @(negedge clk);
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (z80_latch_dout !== 8'h00) begin bad++; $display("FAIL reset_latch1 got=%h exp=00", z80_latch_dout); end
    total++; if (m68k_latch2_dout !== 16'h0000) begin bad++; $display("FAIL reset_latch2 got=%h exp=0000", m68k_latch2_dout); end
    total++; if (z80_nmi_n !== 1'b1) begin bad++; $display("FAIL reset_nmi got=%b exp=1", z80_nmi_n); end
    total++; if (snd_status !== 4'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", snd_status); end
  endtask

  task automatic test_cmd_write();
    int low;
    @(negedge clk);
    falls = 0; low = 0;
    m68k_latch_cs = 1; m68k_uds_n = 0; m68k_dout = {8'hA5, 8'($urandom)};
    model_cmd(8'hA5);
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (z80_nmi_n === 1'b0) low++;
      total++; if (z80_nmi_n !== m_nmi()) begin bad++; $display("FAIL cmd_nmi_cycle j=%0d got=%b exp=%b", j, z80_nmi_n, m_nmi()); end
      if (j == 0) begin
        total++; if (z80_latch_dout !== 8'hA5) begin bad++; $display("FAIL cmd_latch got=%h exp=a5", z80_latch_dout); end
      end
      if (j == 5) bus_idle();
    end
    total++; if (low !== N) begin bad++; $display("FAIL cmd_low_len got=%0d exp=%0d", low, N); end
    total++; if (falls !== 1) begin bad++; $display("FAIL cmd_falls got=%0d exp=1", falls); end
    total++; if (snd_status !== m_status()) begin bad++; $display("FAIL cmd_status got=%h exp=%h", snd_status, m_status()); end
  endtask

  task automatic test_lower_only();
    @(negedge clk);
    falls = 0;
    m68k_latch_cs = 1; m68k_uds_n = 1; m68k_dout = 16'h77CC;
    repeat (3) @(negedge clk);
    bus_idle();
    @(negedge clk);
    total++; if (z80_latch_dout !== m_l1) begin bad++; $display("FAIL lower_latch got=%h exp=%h", z80_latch_dout, m_l1); end
    total++; if (z80_nmi_n !== 1'b1) begin bad++; $display("FAIL lower_nmi got=%b exp=1", z80_nmi_n); end
    total++; if (falls !== 0) begin bad++; $display("FAIL lower_falls got=%0d exp=0", falls); end
    total++; if (snd_status !== m_status()) begin bad++; $display("FAIL lower_status got=%h exp=%h", snd_status, m_status()); end
  endtask

  task automatic test_stretch();
    int t0, low;
    @(negedge clk);
    t0 = cyc; falls = 0; low = 0;
    m68k_latch_cs = 1; m68k_uds_n = 0; m68k_dout = 16'h1100;
    model_cmd(8'h11);
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      if (z80_nmi_n === 1'b0) low++;
      total++; if (z80_nmi_n !== m_nmi()) begin bad++; $display("FAIL stretch_nmi_cycle j=%0d got=%b exp=%b", j, z80_nmi_n, m_nmi()); end
      if (j == 3) bus_idle();
      if (cyc == t0 + 10) begin
        m68k_latch_cs = 1; m68k_uds_n = 0; m68k_dout = 16'h3C00;
        model_cmd(8'h3C);
      end
      if (cyc == t0 + 13) bus_idle();
    end
    total++; if (low !== 26) begin bad++; $display("FAIL stretch_low_len got=%0d exp=26", low); end
    total++; if (falls !== 1) begin bad++; $display("FAIL stretch_falls got=%0d exp=1", falls); end
    total++; if (z80_latch_dout !== 8'h3C) begin bad++; $display("FAIL stretch_latch got=%h exp=3c", z80_latch_dout); end
  endtask

  task automatic test_z80_write();
    @(negedge clk);
    z80_latch_cs = 1; z80_wr_n = 0; z80_dout = 8'h5A;
    model_z80_wr(8'h5A);
    @(negedge clk);
    total++; if (m68k_latch2_dout !== 16'h5A5A) begin bad++; $display("FAIL z80wr_latch2 got=%h exp=5a5a", m68k_latch2_dout); end
    total++; if (snd_status !== m_status()) begin bad++; $display("FAIL z80wr_status got=%h exp=%h", snd_status, m_status()); end
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    z80_latch_read_cs = 1;
    m_p2 = 0;
    repeat (2) @(negedge clk);
    bus_idle();
    total++; if (snd_status !== m_status()) begin bad++; $display("FAIL m68krd_status got=%h exp=%h", snd_status, m_status()); end
    total++; if (m68k_latch2_dout !== 16'h5A5A) begin bad++; $display("FAIL m68krd_data got=%h exp=5a5a", m68k_latch2_dout); end
  endtask

  task automatic test_overrun();
    logic [3:0] exp_fixed;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      m68k_latch_cs = 1; m68k_uds_n = 0; m68k_dout = {8'(8'h40 + k), 8'h00};
      model_cmd(8'(8'h40 + k));
      repeat (2) @(negedge clk);
      bus_idle();
    end
    @(negedge clk);
`ifdef SND_LATCH_STATUS_EN
    exp_fixed = 4'h5;
`else
    exp_fixed = 4'h0;
`endif
    total++; if (snd_status !== exp_fixed) begin bad++; $display("FAIL overrun_status got=%h exp=%h", snd_status, exp_fixed); end
    total++; if (z80_latch_dout !== 8'h41) begin bad++; $display("FAIL overrun_latch got=%h exp=41", z80_latch_dout); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    z80_latch_cs = 1; z80_rd_n = 0;
    m68k_latch_cs = 1; m68k_uds_n = 0; m68k_dout = 16'h9900;
    m_p1 = 0;
    model_cmd(8'h99);
    repeat (2) @(negedge clk);
    bus_idle();
    total++; if (snd_status !== m_status()) begin bad++; $display("FAIL simul_status got=%h exp=%h", snd_status, m_status()); end
    total++; if (z80_latch_dout !== 8'h99) begin bad++; $display("FAIL simul_latch got=%h exp=99", z80_latch_dout); end
    repeat (N + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid_pulse();
    int t0;
    @(negedge clk);
    z80_latch_cs = 1; z80_wr_n = 0; z80_dout = 8'hE7;
    model_z80_wr(8'hE7);
    @(negedge clk);
    bus_idle();
    t0 = cyc;
    m68k_latch_cs = 1; m68k_uds_n = 0; m68k_dout = 16'hC300;
    model_cmd(8'hC3);
    while (cyc < t0 + 5) @(negedge clk);
    total++; if (z80_nmi_n !== 1'b0) begin bad++; $display("FAIL midpulse_pre_nmi got=%b exp=0", z80_nmi_n); end
    #2 reset_n = 0;
    #1;
    total++; if (z80_nmi_n !== 1'b1) begin bad++; $display("FAIL midpulse_nmi got=%b exp=1", z80_nmi_n); end
    total++; if (z80_latch_dout !== 8'h00) begin bad++; $display("FAIL midpulse_latch1 got=%h exp=00", z80_latch_dout); end
    total++; if (m68k_latch2_dout !== 16'h0000) begin bad++; $display("FAIL midpulse_latch2 got=%h exp=0000", m68k_latch2_dout); end
    total++; if (snd_status !== 4'h0) begin bad++; $display("FAIL midpulse_status got=%h exp=0", snd_status); end
    bus_idle();
    @(negedge clk);
    reset_n = 1;
    model_reset();
    @(negedge clk);
    total++; if (z80_nmi_n !== 1'b1) begin bad++; $display("FAIL midpulse_after_nmi got=%b exp=1", z80_nmi_n); end
  endtask

  task automatic test_random();
    int kind, len, gap;
    logic [7:0] b;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 4);
      len  = $urandom_range(1, 4);
      gap  = $urandom_range(1, 3);
      b    = 8'($urandom);
      for (int j = 0; j < len + gap; j++) begin
        @(negedge clk);
        total++; if (z80_latch_dout !== m_l1) begin bad++; $display("FAIL rnd_latch1 t=%0d got=%h exp=%h", t, z80_latch_dout, m_l1); end
        total++; if (m68k_latch2_dout !== {m_l2, m_l2}) begin bad++; $display("FAIL rnd_latch2 t=%0d got=%h exp=%h", t, m68k_latch2_dout, {m_l2, m_l2}); end
        total++; if (z80_nmi_n !== m_nmi()) begin bad++; $display("FAIL rnd_nmi t=%0d got=%b exp=%b", t, z80_nmi_n, m_nmi()); end
        total++; if (snd_status !== m_status()) begin bad++; $display("FAIL rnd_status t=%0d got=%h exp=%h", t, snd_status, m_status()); end
        if (j == 0) begin
          case (kind)
            0: begin m68k_latch_cs = 1; m68k_uds_n = 0; m68k_dout = {b, 8'($urandom)}; model_cmd(b); end
            1: begin m68k_latch_cs = 1; m68k_uds_n = 1; m68k_dout = {b, 8'($urandom)}; end
            2: begin z80_latch_cs = 1; z80_wr_n = 0; z80_dout = b; model_z80_wr(b); end
            3: begin z80_latch_cs = 1; z80_rd_n = 0; z80_dout = b; m_p1 = 0; end
            default: begin z80_latch_read_cs = 1; m_p2 = 0; end
          endcase
        end
        if (j == len - 1 + 1) bus_idle();
      end
    end
  endtask

  initial begin
    reset_n = 0;
    bus_idle();
    m68k_dout = 16'h0000;
    z80_dout = 8'h00;
    model_reset();
    test_reset();
    test_cmd_write();
    test_lower_only();
    test_stretch();
    test_z80_write();
    test_overrun();
    test_simultaneous();
    test_reset_mid_pulse();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
